// File: rtl/popcount_pipe.sv
// popcount_pipe
// -------------
// Pipelined population count for a WIDTH-bit word. The count is built by a
// pairwise adder tree with one register per tree level; the last tree level
// is the output register, so a word accepted on edge n is presented from
// edge n+LEVELS-1 onward (no stalls). A valid/ready handshake provides full
// backpressure: while a result sits unconsumed the whole pipeline freezes.
//
// Optional accumulate mode is compiled in when POPCOUNT_PIPE_ACC_EN is
// defined. Groups of in_mode=1 beats are summed into a saturating
// ACC_W-bit accumulator and one result is emitted on the in_last beat.
// Without the macro, in_mode/in_last are ignored and out_ovf is tied low.
//
// Parameters:
//   WIDTH  input word width, power of two, >= 2
//   ACC_W  result/accumulator width, must be >= $clog2(WIDTH)+1
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   block can accept a word this cycle
//   in_data    word to count
//   in_mode    0 = per-word count, 1 = accumulate
//   in_last    final word of an accumulate group
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   result (zero-extended count in per-word mode)
//   out_ovf    accumulate group saturated

module popcount_pipe #(
  parameter int WIDTH = 64,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int OUT_W  = LEVELS + 1;

  // The whole pipe moves together; a held result freezes every stage so no
  // bubbles are collapsed and ordering is trivially preserved.
  logic stall;
  logic advance;

  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;

  // Tree levels 1 .. LEVELS-1. Level k holds WIDTH>>k sums of k+1 bits.
  for (genvar k = 1; k < LEVELS; k++) begin : g_lvl
    localparam int N = WIDTH >> k;

    logic [k:0] sum_d [N];
    logic [k:0] sum_q [N];
    logic       prv_vld;
    logic       vld_q;
`ifdef POPCOUNT_PIPE_ACC_EN
    logic       prv_mode;
    logic       prv_last;
    logic       mode_q;
    logic       last_q;
`endif

    if (k == 1) begin : g_src
      for (genvar i = 0; i < N; i++) begin : g_add
        assign sum_d[i] = {1'b0, in_data[2*i]} + {1'b0, in_data[2*i+1]};
      end
      assign prv_vld = in_valid;
`ifdef POPCOUNT_PIPE_ACC_EN
      assign prv_mode = in_mode;
      assign prv_last = in_last;
`endif
    end else begin : g_src
      for (genvar i = 0; i < N; i++) begin : g_add
        assign sum_d[i] = {1'b0, g_lvl[k-1].sum_q[2*i]}
                        + {1'b0, g_lvl[k-1].sum_q[2*i+1]};
      end
      assign prv_vld = g_lvl[k-1].vld_q;
`ifdef POPCOUNT_PIPE_ACC_EN
      assign prv_mode = g_lvl[k-1].mode_q;
      assign prv_last = g_lvl[k-1].last_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
`ifdef POPCOUNT_PIPE_ACC_EN
        mode_q <= 1'b0;
        last_q <= 1'b0;
`endif
        for (int i = 0; i < N; i++) sum_q[i] <= '0;
      end else if (advance) begin
        vld_q <= prv_vld;
`ifdef POPCOUNT_PIPE_ACC_EN
        mode_q <= prv_mode;
        last_q <= prv_last;
`endif
        for (int i = 0; i < N; i++) sum_q[i] <= sum_d[i];
      end
    end
  end

  // Inputs to the final level: either straight from the word (WIDTH=2) or
  // from the last tree register.
  logic             fin_vld;
  logic [OUT_W-1:0] fin_count;
`ifdef POPCOUNT_PIPE_ACC_EN
  logic             fin_mode;
  logic             fin_last;
`endif

  if (LEVELS == 1) begin : g_fin_direct
    assign fin_vld   = in_valid;
    assign fin_count = OUT_W'(in_data[0]) + OUT_W'(in_data[1]);
`ifdef POPCOUNT_PIPE_ACC_EN
    assign fin_mode  = in_mode;
    assign fin_last  = in_last;
`endif
  end else begin : g_fin_tree
    assign fin_vld   = g_lvl[LEVELS-1].vld_q;
    assign fin_count = OUT_W'(g_lvl[LEVELS-1].sum_q[0])
                     + OUT_W'(g_lvl[LEVELS-1].sum_q[1]);
`ifdef POPCOUNT_PIPE_ACC_EN
    assign fin_mode  = g_lvl[LEVELS-1].mode_q;
    assign fin_last  = g_lvl[LEVELS-1].last_q;
`endif
  end

  logic             fin_emit;
  logic [ACC_W-1:0] fin_result;

`ifdef POPCOUNT_PIPE_ACC_EN
  logic [ACC_W-1:0] acc_q;
  logic             sticky_q;
  logic [ACC_W:0]   acc_sum;
  logic             acc_sat;
  logic [ACC_W-1:0] acc_val;

  // One extra bit on the add catches saturation directly.
  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(fin_count);
  assign acc_sat = acc_sum[ACC_W];
  assign acc_val = acc_sat ? '1 : acc_sum[ACC_W-1:0];

  // Non-last accumulate beats are absorbed and leave a bubble at the output.
  assign fin_emit   = fin_vld && (!fin_mode || fin_last);
  assign fin_result = fin_mode ? acc_val : ACC_W'(fin_count);

  // Accumulator and sticky overflow move only with the pipe. Per-word beats
  // in the middle of a group leave them alone; the last beat clears them in
  // the same edge that loads the group result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (advance) begin
      if (fin_vld && fin_mode && !fin_last) begin
        acc_q    <= acc_val;
        sticky_q <= sticky_q || acc_sat;
      end else if (fin_vld && fin_mode) begin
        acc_q    <= '0;
        sticky_q <= 1'b0;
        out_ovf  <= sticky_q || acc_sat;
      end else if (fin_vld) begin
        out_ovf  <= 1'b0;
      end
    end
  end
`else
  logic unused_sideband;

  assign unused_sideband = in_mode ^ in_last;
  assign fin_emit        = fin_vld;
  assign fin_result      = ACC_W'(fin_count);
  assign out_ovf         = 1'b0;
`endif

  // Output register: this is tree level LEVELS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= fin_emit;
      if (fin_emit) out_data <= fin_result;
    end
  end

endmodule

// File: tb/tb_popcount_pipe.sv
// tb_popcount_pipe
// ----------------
// Directed bench for popcount_pipe (WIDTH=64, ACC_W=16). A negedge monitor
// keeps an in-order queue of expected results built from accepted words and
// compares every consumed result against it; directed checks add hand-made
// values for latency, backpressure, accumulate and reset behaviour.
// Accumulate cases are compiled when POPCOUNT_PIPE_ACC_EN is defined.

module tb_popcount_pipe;

  localparam int WIDTH   = 64;
  localparam int ACC_W   = 16;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vector_count = 0;
  int   miss_count   = 0;
  int   model_acc    = 0;
  bit   model_ovf    = 1'b0;

  popcount_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference behaviour for an accepted word.
  task automatic modelAccept(input logic [WIDTH-1:0] data, input logic mode,
                             input logic last);
    exp_t e;
    int   cnt;
    int   sum;
    cnt = $countones(data);
`ifdef POPCOUNT_PIPE_ACC_EN
    if (mode) begin
      sum = model_acc + cnt;
      if (sum > ACC_MAX) begin
        sum       = ACC_MAX;
        model_ovf = 1'b1;
      end
      if (last) begin
        e.data = ACC_W'(sum);
        e.ovf  = model_ovf;
        exp_q.push_back(e);
        model_acc = 0;
        model_ovf = 1'b0;
      end else begin
        model_acc = sum;
      end
    end else begin
      e.data = ACC_W'(cnt);
      e.ovf  = 1'b0;
      exp_q.push_back(e);
    end
`else
    e.data = ACC_W'(cnt);
    e.ovf  = 1'b0;
    exp_q.push_back(e);
    if (mode && last) sum = 0;
`endif
  endtask

  // Scoreboard: both handshakes are evaluated half a cycle before the edge
  // at which they take effect.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_result", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("result_data", out_data, e.data);
          checkOutput("result_ovf", out_ovf, e.ovf);
        end
      end
      if (in_valid && in_ready) modelAccept(in_data, in_mode, in_last);
    end
  end

  // Offer one word and hold it until accepted; returns at edge+1 with
  // in_valid low so a following call keeps the stream back-to-back.
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic mode,
                               input logic last, output int waits);
    bit taken;
    waits    = 0;
    taken    = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    in_last  = last;
    while (!taken && waits < 200) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
      if (!taken) waits++;
    end
    if (!taken) checkOutput("accept_timeout", 64'(waits), 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for the next presented result and compare to hand values.
  task automatic waitResult(input string tag, input logic [ACC_W-1:0] exp_data,
                            input logic exp_ovf);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        checkOutput({tag, "_data"}, out_data, exp_data);
        checkOutput({tag, "_ovf"}, out_ovf, exp_ovf);
      end
      @(posedge clk);
      #1;
    end
    if (!seen) checkOutput({tag, "_timeout"}, out_valid, 1'b1);
  endtask

  task automatic drainCheck(input string tag, input int cycles);
    idleCycles(cycles);
    checkOutput(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] lat_vec [3];
    logic [ACC_W-1:0] lat_exp [3];
    int w;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #23;
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_out_data", out_data, 64'd0);
    checkOutput("reset_out_ovf", out_ovf, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1'b1);

    // Latency: first word accepted at edge e=0 shows up after edge e=5.
    $display("[TB] latency and basic counts");
    lat_vec[0] = 64'h0;                 lat_exp[0] = 16'd0;
    lat_vec[1] = 64'hFFFF_FFFF_FFFF_FFFF; lat_exp[1] = 16'd64;
    lat_vec[2] = 64'h8000_0000_0000_0001; lat_exp[2] = 16'd2;
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_last  = 1'b0;
    in_data  = lat_vec[0];
    for (int e = 0; e < 9; e++) begin
      @(posedge clk);
      #1;
      checkOutput("lat_valid", out_valid, (e >= 5 && e <= 7));
      if (e >= 5 && e <= 7) checkOutput("lat_data", out_data, lat_exp[e-5]);
      if (e + 1 < 3) in_data = lat_vec[e+1];
      else in_valid = 1'b0;
    end
    drainCheck("lat_drain", 3);

    // Back-to-back random words, never stalled.
    $display("[TB] random stream");
    for (int i = 0; i < 1000; i++) begin
      applyStimulus({$urandom, $urandom}, 1'b0, 1'b0, w);
      checkOutput("rand_in_ready", 64'(w), 64'd0);
    end
    drainCheck("rand_drain", 6);

    // Backpressure: 8 words offered while downstream holds off 10 cycles.
    $display("[TB] backpressure");
    out_ready = 1'b0;
    fork
      begin
        int ww;
        for (int i = 0; i < 8; i++)
          applyStimulus({64{1'b1}} >> (63 - i), 1'b0, 1'b0, ww);
      end
      begin
        idleCycles(10);
        checkOutput("stall_in_ready", in_ready, 1'b0);
        checkOutput("stall_out_valid", out_valid, 1'b1);
        checkOutput("stall_head_data", out_data, 64'd1);
        out_ready = 1'b1;
      end
    join
    drainCheck("stall_drain", 12);

`ifdef POPCOUNT_PIPE_ACC_EN
    $display("[TB] accumulate groups");
    for (int i = 0; i < 4; i++) applyStimulus('1, 1'b1, (i == 3), w);
    waitResult("grp4", 16'd256, 1'b0);
    drainCheck("grp4_drain", 2);

    // Per-word beat inside a group passes through untouched.
    applyStimulus('1, 1'b1, 1'b0, w);
    applyStimulus(64'hF, 1'b0, 1'b0, w);
    applyStimulus('1, 1'b1, 1'b1, w);
    waitResult("mid_word", 16'd4, 1'b0);
    waitResult("mid_group", 16'd128, 1'b0);

    // 1024*64 = 65536 saturates on the last non-last beat: sticky carries it.
    for (int i = 0; i < 1024; i++) applyStimulus('1, 1'b1, 1'b0, w);
    applyStimulus(64'h0, 1'b1, 1'b1, w);
    waitResult("sat_group", 16'hFFFF, 1'b1);
    applyStimulus(64'h3, 1'b1, 1'b1, w);
    waitResult("after_sat", 16'd2, 1'b0);
`else
    $display("[TB] mode ignored without accumulate");
    applyStimulus('1, 1'b1, 1'b0, w);
    applyStimulus(64'h3, 1'b1, 1'b1, w);
    waitResult("noacc_a", 16'd64, 1'b0);
    waitResult("noacc_b", 16'd2, 1'b0);
`endif
    drainCheck("acc_drain", 4);

    // Reset with results held and a group half built.
    $display("[TB] mid-operation reset");
    out_ready = 1'b0;
    applyStimulus(64'hFF, 1'b0, 1'b0, w);
    applyStimulus(64'hFF, 1'b0, 1'b0, w);
    applyStimulus('1, 1'b1, 1'b0, w);
    applyStimulus('1, 1'b1, 1'b0, w);
    idleCycles(6);
    checkOutput("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_out_ovf", out_ovf, 1'b0);
    exp_q.delete();
    model_acc = 0;
    model_ovf = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1'b1);
`ifdef POPCOUNT_PIPE_ACC_EN
    applyStimulus(64'h3, 1'b1, 1'b0, w);
    applyStimulus(64'h3, 1'b1, 1'b1, w);
    waitResult("post_rst_group", 16'd4, 1'b0);
`else
    applyStimulus(64'h3, 1'b1, 1'b0, w);
    applyStimulus(64'h7, 1'b1, 1'b1, w);
    waitResult("post_rst_a", 16'd2, 1'b0);
    waitResult("post_rst_b", 16'd3, 1'b0);
`endif
    drainCheck("final_drain", 8);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
